switch_allocator_rr: RTL and testbench
======================================

Name: switch_allocator_rr

Overview:
- Parametrised, registered switch allocator for the chiplet switch, sitting between the input buffers and the crossbar.
- Accepts one allocation request per input buffer per cycle and arbitrates each output port independently with a round-robin pointer.
- Holds each grant until the owning buffer's valid drops, which marks the packet tail; the port is then released.
- Drives per-outport select/enable to the crossbar and a per-buffer grant vector back to the buffers.

Parameters:
- NUM_BUFFERS, 5, number of input buffers (requestors); at least 1.
- NUM_OUTPORTS, 5, number of output ports; at least 1.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with SWITCH_ALLOC_TIMEOUT_EN.
- Derived: REQ_W = $clog2(NUM_OUTPORTS)+(NUM_OUTPORTS==1); SEL_W = $clog2(NUM_BUFFERS)+(NUM_BUFFERS==1).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- valid  input  NUM_BUFFERS  buffer i still holds flits of its current packet.
- allocate  input  NUM_BUFFERS  buffer i requests an output port this cycle.
- requested  input  NUM_BUFFERS x REQ_W  output port requested by buffer i.
- switch_valid  output  NUM_BUFFERS  buffer i currently owns an output port.
- select  output  NUM_OUTPORTS x SEL_W  owning buffer index for each output port.
- enable  output  NUM_OUTPORTS  output port o is allocated.
- timeout  output  NUM_OUTPORTS  one-cycle pulse when a watchdog forces a release; tied 0 without the feature.

Behaviour:
- Reset (nRST=0, asynchronous):
  - All ports go IDLE; all outputs become 0.
  - Every round-robin pointer is set to NUM_BUFFERS-1, so buffer 0 wins first.
- Each output port runs a two-state FSM, IDLE or BUSY, with a SEL_W owner register and a SEL_W pointer.
- Valid request:
  - allocate[i]=1, requested[i]<NUM_OUTPORTS, and switch_valid[i]=0.
  - Out-of-range requests are ignored.
  - Requests from a buffer that already owns a port are ignored.
- IDLE -> BUSY:
  - Occurs when at least one valid request targets the port.
  - Winner is the first requesting index found scanning ptr+1, ptr+2, ... modulo NUM_BUFFERS.
  - At the edge: owner<=winner, ptr<=winner, enable[o]<=1, select[o]<=winner.
- Latency: the request is sampled in cycle N; the grant is visible in cycle N+1 on switch_valid, enable and select. All outputs are registered.
- Losers receive nothing; they must hold allocate and are re-arbitrated each cycle. Allocate is level-sensitive, so nothing is queued.
- Buffer requests several ports in one cycle: impossible, since requested is a single field per buffer.
- Buffer contending for two ports in one cycle: cannot occur, because each buffer names exactly one port.
- BUSY -> IDLE:
  - Triggered when valid[owner]=0 is sampled.
  - At the edge, enable[o]<=0 and switch_valid[owner]<=0; select[o] holds its last value.
  - The port is re-arbitrable from the following cycle, so there is at least one idle cycle between owners.
- Same-cycle re-request: a buffer whose valid drops and which asserts allocate in the same cycle is treated as still owning, so the request is ignored. It must re-request after switch_valid falls.
- While BUSY, allocate and valid of non-owners are ignored for that port.
- switch_valid[i] = OR over o of (enable[o] && owner[o]==i). The output is registered, consistent with enable.
- Reset mid-packet: all grants are dropped immediately and the pointers are reinitialised.

Optional Feature:
- Macro: SWITCH_ALLOC_TIMEOUT_EN.
- With the macro defined:
  - Each port has a counter cleared on grant and incremented every BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 with valid[owner] still 1, the port is forced IDLE at the next edge and timeout[o] pulses for one cycle.
  - The pointer keeps the stalled owner, so that buffer has lowest priority next.
- Without the macro: no counters are built, timeout is tied 0, and release happens only on valid drop.

Test Plan:
- Single request: reset, then allocate[2]=1, requested[2]=3 -> next cycle enable=5'b01000, select[3]=2, switch_valid=5'b00100.
- Contention: buffers 0, 1, 4 all request port 1 from reset -> grant order 0, then 1, then 4 across three packets. Drop each owner's valid after 4 cycles; each port shows one idle cycle between owners.
- Parallel grants: buffer 0 requests port 2 and buffer 3 requests port 0 in the same cycle -> both granted the next cycle, enable=5'b00101.
- Ignore rules:
  - requested=7 with NUM_OUTPORTS=5 -> no grant.
  - An owning buffer re-requesting another port -> no grant until its valid drops.
- Async reset while 3 ports are BUSY: nRST pulsed low mid-cycle -> enable, select and switch_valid go to 0 before the next edge. After release, buffer 0 wins a tie against buffer 3.
- With SWITCH_ALLOC_TIMEOUT_EN and TIMEOUT_CYCLES=8: the owner holds valid high -> timeout[o] pulses 8 cycles after the grant, the port is released, and a waiting buffer is granted on the following arbitration.

Source files
------------

// File: rtl/switch_allocator_rr_if.sv
// switch_allocator_rr_if
//   Handshake bundle between the input buffers and the switch allocator.
//   master : buffer side (drives valid/allocate/requested, sees grants)
//   slave  : allocator side
//   Signals:
//     valid        [NUM_BUFFERS]         buffer still holds flits of its packet
//     allocate     [NUM_BUFFERS]         buffer requests an output port
//     requested    [NUM_BUFFERS][REQ_W]  port requested by each buffer
//     switch_valid [NUM_BUFFERS]         buffer currently owns a port
//     select       [NUM_OUTPORTS][SEL_W] owning buffer per port
//     enable       [NUM_OUTPORTS]        port allocated
//     timeout      [NUM_OUTPORTS]        watchdog release pulse
interface switch_allocator_rr_if #(
  parameter int NUM_BUFFERS  = 5,
  parameter int NUM_OUTPORTS = 5
);
  localparam int REQ_W = $clog2(NUM_OUTPORTS) + ((NUM_OUTPORTS == 1) ? 1 : 0);
  localparam int SEL_W = $clog2(NUM_BUFFERS) + ((NUM_BUFFERS == 1) ? 1 : 0);

  logic [NUM_BUFFERS-1:0]             valid;
  logic [NUM_BUFFERS-1:0]             allocate;
  logic [NUM_BUFFERS-1:0][REQ_W-1:0]  requested;
  logic [NUM_BUFFERS-1:0]             switch_valid;
  logic [NUM_OUTPORTS-1:0][SEL_W-1:0] select;
  logic [NUM_OUTPORTS-1:0]            enable;
  logic [NUM_OUTPORTS-1:0]            timeout;

  modport master (output valid, allocate, requested,
                  input  switch_valid, select, enable, timeout);
  modport slave  (input  valid, allocate, requested,
                  output switch_valid, select, enable, timeout);
endinterface

// File: rtl/switch_allocator_rr.sv
// switch_allocator_rr
//   Registered per-output-port round-robin switch allocator. Each port grants
//   one buffer and holds it until that buffer's valid drops (packet tail).
//   Ports:
//     CLK   clock, rising edge
//     nRST  asynchronous active-low reset
//     bus   switch_allocator_rr_if.slave (requests in, grants/selects out)
//   Optional feature: define SWITCH_ALLOC_TIMEOUT_EN to add a per-port
//   watchdog that force-releases a port after TIMEOUT_CYCLES busy cycles.

// One output port: IDLE/BUSY FSM, owner register and round-robin pointer.
module switch_alloc_port #(
  parameter int NB    = 5,
  parameter int SEL_W = 3
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NB-1:0]    req_i,    // qualified requests aimed at this port
  input  logic [NB-1:0]    valid_i,
  output logic             en_q_o,
  output logic             en_d_o,
  output logic [SEL_W-1:0] own_q_o,
  output logic [SEL_W-1:0] own_d_o,
  output logic             to_q_o
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           st_q, st_d;
  logic [SEL_W-1:0] own_q, own_d, ptr_q, ptr_d;
  logic             found;
  logic [SEL_W-1:0] win;
  logic             to_d;

`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q;
`endif

  // Scan ptr+1, ptr+2, ... (mod NB); first requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NB; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NB) idx = idx - NB;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    st_d  = st_q;
    own_d = own_q;
    ptr_d = ptr_q;
    to_d  = 1'b0;
    case (st_q)
      IDLE: if (found) begin
        st_d  = BUSY;
        own_d = win;
        ptr_d = win;
      end
      BUSY: begin
        if (!valid_i[own_q]) st_d = IDLE;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        // Stalled owner: release but leave ptr on it so it ranks last next.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          st_d = IDLE;
          to_d = 1'b1;
        end
`endif
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q  <= IDLE;
      own_q <= '0;
      ptr_q <= SEL_W'(NB - 1);
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      ptr_q <= ptr_d;
    end
  end

`ifdef SWITCH_ALLOC_TIMEOUT_EN
  // Counter sits at 0 while idle, so the first busy cycle reads 0.
  assign cnt_d = (st_q == BUSY) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  assign to_q_o = to_q;
`else
  assign to_q_o = 1'b0;
`endif

  assign en_q_o  = (st_q == BUSY);
  assign en_d_o  = (st_d == BUSY);
  assign own_q_o = own_q;
  assign own_d_o = own_d;
endmodule

module switch_allocator_rr #(
  parameter int NUM_BUFFERS    = 5,
  parameter int NUM_OUTPORTS   = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  nRST,
  switch_allocator_rr_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_BUFFERS) + ((NUM_BUFFERS == 1) ? 1 : 0);

  if (NUM_BUFFERS < 1 || NUM_OUTPORTS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("switch_allocator_rr: illegal parameter value");
  end

  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] hit;
  logic [NUM_OUTPORTS-1:0]                  en_q, en_d, to_q;
  logic [NUM_OUTPORTS-1:0][SEL_W-1:0]       own_q, own_d;
  logic [NUM_BUFFERS-1:0]                   sv_q, sv_d;

  // Owners are masked via the registered switch_valid, so a buffer dropping
  // valid and re-requesting in the same cycle is still treated as owning.
  // Out-of-range port numbers never match any o and fall away here.
  always_comb begin
    hit = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++)
      for (int b = 0; b < NUM_BUFFERS; b++)
        hit[o][b] = bus.allocate[b] && !sv_q[b] && (int'(bus.requested[b]) == o);
  end

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_port
    switch_alloc_port #(
      .NB    (NUM_BUFFERS),
      .SEL_W (SEL_W)
`ifdef SWITCH_ALLOC_TIMEOUT_EN
      , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_port (
      .CLK     (CLK),
      .nRST    (nRST),
      .req_i   (hit[o]),
      .valid_i (bus.valid),
      .en_q_o  (en_q[o]),
      .en_d_o  (en_d[o]),
      .own_q_o (own_q[o]),
      .own_d_o (own_d[o]),
      .to_q_o  (to_q[o])
    );
  end

  // Decode ownership from next-state so switch_valid is a flop aligned with enable.
  always_comb begin
    sv_d = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++)
      if (en_d[o]) sv_d[int'(own_d[o])] = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) sv_q <= '0;
    else       sv_q <= sv_d;
  end

  assign bus.switch_valid = sv_q;
  assign bus.enable       = en_q;
  assign bus.select       = own_q;
  assign bus.timeout      = to_q;
endmodule

// File: tb/tb_switch_allocator_rr.sv
module tb_switch_allocator_rr;
  localparam int NB = 5, NO = 5, SW = 3, RW = 3;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  switch_allocator_rr_if #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO)) bus();

  switch_allocator_rr #(
    .NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NO-1:0]         en;
    logic [NO-1:0][SW-1:0] sel;
    logic [NB-1:0]         sv;
    logic [NO-1:0]         to;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference state: who owns each port, its rr pointer, cycles since grant.
  int m_busy[NO], m_own[NO], m_ptr[NO], m_age[NO];
  logic [NB-1:0][RW-1:0] rr;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int o = 0; o < NO; o++) begin
      m_busy[o] = 0; m_own[o] = 0; m_ptr[o] = NB - 1; m_age[o] = 0;
    end
  endfunction

  function automatic bit owns(int b);
    for (int o = 0; o < NO; o++) if (m_busy[o] != 0 && m_own[o] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Drive inputs now and push the outputs expected after the next edge.
  task automatic apply(input logic [NB-1:0] v, input logic [NB-1:0] a,
                       input logic [NB-1:0][RW-1:0] r);
    exp_t e;
    bit   own_now[NB];
    int   best, bestd, d;
    bus.valid = v; bus.allocate = a; bus.requested = r;
    for (int b = 0; b < NB; b++) own_now[b] = owns(b);
    e.to = '0;
    for (int o = 0; o < NO; o++) begin
      if (m_busy[o] != 0) begin
        if (!v[m_own[o]]) m_busy[o] = 0;
        else if (TO_ON && m_age[o] == TO - 1) begin m_busy[o] = 0; e.to[o] = 1'b1; end
        else m_age[o]++;
      end else begin
        // Round robin: requester at smallest distance past the pointer wins.
        best = -1; bestd = NB;
        for (int b = 0; b < NB; b++)
          if (a[b] && !own_now[b] && int'(r[b]) == o) begin
            d = (b - m_ptr[o] - 1 + 2 * NB) % NB;
            if (d < bestd) begin bestd = d; best = b; end
          end
        if (best >= 0) begin
          m_busy[o] = 1; m_own[o] = best; m_ptr[o] = best; m_age[o] = 0;
        end
      end
    end
    e.sv = '0;
    for (int o = 0; o < NO; o++) begin
      e.en[o]  = (m_busy[o] != 0);
      e.sel[o] = SW'(m_own[o]);
      if (m_busy[o] != 0) e.sv[m_own[o]] = 1'b1;
    end
    q.push_back(e);
  endtask

  task automatic step(input logic [NB-1:0] v, input logic [NB-1:0] a);
    @(negedge CLK);
    apply(v, a, rr);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_enable"}, 32'(bus.enable), 32'd0);
    chk({tag, "_select"}, 32'(bus.select), 32'd0);
    chk({tag, "_switch_valid"}, 32'(bus.switch_valid), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  // Asynchronous reset pulse in the middle of a low phase.
  task automatic mid_reset();
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1 chk_zero("mid_reset");
    #1 nRST = 1'b1;
    model_reset();
    apply('0, '0, '0);
  endtask

  // Monitor: compares registered outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("enable", 32'(bus.enable), 32'(e.en));
        chk("select", 32'(bus.select), 32'(e.sel));
        chk("switch_valid", 32'(bus.switch_valid), 32'(e.sv));
        chk("timeout", 32'(bus.timeout), 32'(e.to));
      end
    end
  end

  initial begin
    logic [NB-1:0] v, a;
    int hold[NB];
    bit served[NB];
    bus.valid = '0; bus.allocate = '0; bus.requested = '0;
    rr = '0;
    model_reset();
    #12 chk_zero("reset");
    @(negedge CLK);
    nRST = 1'b1;
    apply('0, '0, '0);

    // Single request: buffer 2 -> port 3.
    rr = '0; rr[2] = 3'd3;
    step(5'b00100, 5'b00100);
    step(5'b00100, 5'b00000);
    step(5'b00100, 5'b00000);
    step(5'b00000, 5'b00000);
    step(5'b00000, 5'b00000);

    // Parallel grants, then an owner re-requesting another port.
    rr = '0; rr[0] = 3'd2; rr[3] = 3'd0;
    step(5'b01001, 5'b01001);
    rr[0] = 3'd4;
    step(5'b01001, 5'b00001);
    step(5'b01001, 5'b00001);
    step(5'b01000, 5'b00001);   // tail and re-request together: ignored
    step(5'b01000, 5'b00001);
    step(5'b01001, 5'b00000);
    step(5'b00000, 5'b00000);
    step(5'b00000, 5'b00000);

    // Out-of-range port number.
    rr = '0; rr[1] = 3'd7;
    step(5'b00010, 5'b00010);
    step(5'b00010, 5'b00010);
    step(5'b00000, 5'b00000);

    // Contention on port 1 from buffers 0, 1, 4; each owner holds 4 cycles.
    for (int b = 0; b < NB; b++) begin hold[b] = 0; served[b] = 1'b0; end
    rr = '0; rr[0] = 3'd1; rr[1] = 3'd1; rr[4] = 3'd1;
    for (int c = 0; c < 24; c++) begin
      v = '0; a = '0;
      for (int b = 0; b < NB; b++)
        if ((b == 0 || b == 1 || b == 4) && !served[b]) begin v[b] = 1'b1; a[b] = 1'b1; end
      if (m_busy[1] != 0) begin
        a[m_own[1]] = 1'b0;
        hold[m_own[1]]++;
        if (hold[m_own[1]] >= 4) begin v[m_own[1]] = 1'b0; served[m_own[1]] = 1'b1; end
      end
      step(v, a);
    end
    step(5'b00000, 5'b00000);

    // Three ports busy, then async reset, then a 0-vs-3 tie.
    rr = '0; rr[0] = 3'd0; rr[1] = 3'd2; rr[2] = 3'd4;
    step(5'b00111, 5'b00111);
    step(5'b00111, 5'b00000);
    mid_reset();
    rr = '0; rr[0] = 3'd1; rr[3] = 3'd1;
    step(5'b01001, 5'b01001);
    step(5'b01001, 5'b01000);
    step(5'b01000, 5'b01000);
    step(5'b01000, 5'b01000);
    step(5'b01000, 5'b00000);
    step(5'b00000, 5'b00000);

    // Long-held owner with a waiter (exercises the watchdog when built in).
    rr = '0; rr[0] = 3'd3; rr[1] = 3'd3;
    step(5'b00011, 5'b00011);
    repeat (14) step(5'b00011, 5'b00010);
    step(5'b00000, 5'b00000);
    step(5'b00000, 5'b00000);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) mid_reset();
      else begin
        for (int b = 0; b < NB; b++) begin
          if (owns(b)) begin
            v[b] = ($urandom % 5) != 0;
            a[b] = ($urandom % 4) == 0;
          end else begin
            v[b] = 1'($urandom % 2);
            a[b] = 1'($urandom % 2);
          end
          rr[b] = (($urandom % 8) == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
        end
        step(v, a);
      end
    end

    repeat (3) @(negedge CLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
